silent_stepper: RTL and testbench
=================================

Name: silent_stepper

Overview:
- Slew-rate limiter for per-transducer duty/phase targets.
- Sits between the modulation/sequence select stage and the per-transducer delay/PWM stage.
- On each START tick it walks all TRANS_NUM channels serially, one per CLK, and moves each stored output at most STEP counts toward its target.
- Provides silent-mode smoothing with one shared arithmetic datapath instead of TRANS_NUM parallel filters.

Parameters:
- TRANS_NUM, 249, number of transducer channels (1..256).
- IDX_W, 8, channel index width; must satisfy 2**IDX_W >= TRANS_NUM.

Ports:
- CLK  input  1  system clock; reset is synchronous and active-low.
- RST_N  input  1  synchronous active-low reset.
- START  input  1  one-cycle update tick.
- STEP  input  8  maximum change per tick; sampled when START is accepted.
- DUTY  input  8 x TRANS_NUM  target duty per channel.
- PHASE  input  8 x TRANS_NUM  target phase per channel.
- DUTYS  output  8 x TRANS_NUM  stepped duty per channel.
- PHASES  output  8 x TRANS_NUM  stepped phase per channel.
- BUSY  output  1  high while a sweep is in progress.
- DONE  output  1  one-cycle pulse after the last channel is written.
- OVERRUN  output  1  one-cycle pulse when START arrives while BUSY.

Behaviour:
- Reset (RST_N low at an edge):
  - All DUTYS and PHASES become 0.
  - BUSY=0, DONE=0, OVERRUN=0, IDX=0, state IDLE.
  - Reset during RUN aborts the sweep immediately. No DONE is issued. Channels already written are also cleared to 0.
- FSM states: IDLE and RUN.
- IDLE:
  - START=1 at edge k: latch STEP into step_q, set IDX=0, go to RUN.
  - BUSY is high from edge k onward.
- RUN:
  - At each edge, write channel IDX from the live DUTY[IDX], PHASE[IDX] and the current outputs, then increment IDX.
  - Channel i is updated at edge k+1+i.
  - At edge k+TRANS_NUM (IDX = TRANS_NUM-1): go to IDLE, BUSY=0, and DONE=1 for one cycle.
  - Upstream holds targets stable while BUSY is high. Any mid-sweep change applies only to channels not yet visited.
- START while BUSY (including on the final RUN edge): ignored, OVERRUN=1 for one cycle, sweep unaffected.
- Duty step (unsigned), with t = target, c = current:
  - |t-c| <= step_q: next = t.
  - t > c: next = c + step_q.
  - Otherwise: next = c - step_q.
  - Never overshoots and never wraps. Compute the difference in 9 bits.
- Phase step (circular, with SILENT_PHASE_WRAP_EN defined):
  - d = (t - c) mod 256, interpreted as signed 8-bit.
  - d = 0: no change.
  - |d| <= step_q: next = t.
  - d > 0: next = (c + step_q) mod 256.
  - d < 0: next = (c - step_q) mod 256.
  - d = -128 (0x80) moves in the positive direction.
- step_q = 0: outputs unchanged for the whole sweep. BUSY and DONE still run normally.
- step_q = 255: outputs equal the targets after one sweep.
- Outputs are registered with no combinational path from inputs. Channels not being written hold their value.

Optional Feature:
- Macro: SILENT_PHASE_WRAP_EN.
- Defined: phase uses the circular shortest-path rule above, e.g. 250 -> 5 travels via 255/0.
- Undefined: phase uses the same linear, non-wrapping rule as duty, e.g. 250 -> 5 travels downward through 128.

Decomposition:
- Package silent_pkg:
  - DUTY_W=8, PHASE_W=8.
  - typedef enum {IDLE, RUN} silent_state_t.
  - Pure functions step_linear(c, t, s) and step_circular(c, t, s).
- Sub-module silent_step_unit:
  - Combinational, one channel.
  - Inputs: current duty/phase, target duty/phase, step.
  - Outputs: next duty/phase.
  - Contains the SILENT_PHASE_WRAP_EN ifdef.
- Top level keeps the FSM, IDX counter, output arrays and mux/demux.

Test Plan:
- Reset, all DUTY=200, STEP=50, four START ticks spaced > TRANS_NUM cycles -> DUTYS 50, 100, 150, 200; DONE exactly once per sweep, at edge k+249.
- Channel 0 PHASE=5 from current 250, STEP=4 -> PHASES[0] 254, 2, 5 with macro; 246, 242, ... without macro.
- Duty 10 -> 12 with STEP=5 -> 12 after one sweep, no overshoot; duty 12 -> 0 with STEP=20 -> 0, no wrap.
- START held high for 3 consecutive cycles -> one sweep; OVERRUN pulses twice; DONE once.
- RST_N low at sweep channel 100 -> all outputs 0 next cycle, BUSY=0, no DONE; a new START then performs a full sweep from 0.
- STEP=0 with targets != outputs -> outputs unchanged; BUSY high for exactly 249 cycles, then DONE.

Source files
------------

// File: rtl/silent_pkg.sv
`default_nettype none
// ============================================================================
// Module      : silent_pkg
// Description : Shared widths, FSM state encoding and per-channel step
//               arithmetic for the silent_stepper slew-rate limiter.
//               step_linear   - unsigned, saturating move toward a target.
//               step_circular - shortest-path move on a mod-256 circle.
//               Which rule applies to phase is chosen in silent_step_unit
//               by the SILENT_PHASE_WRAP_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
package silent_pkg;

    localparam int DUTY_W  = 8;
    localparam int PHASE_W = 8;
    localparam int STEP_W  = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } silent_state_t;

    // Move c toward t by at most s. The distance is formed in 9 bits, so the
    // result never passes the target and never wraps past 0 or 255.
    function automatic logic [7:0] step_linear(
        input logic [7:0] c,
        input logic [7:0] t,
        input logic [7:0] s
    );
        logic [8:0] diff;
        if (t >= c) begin
            diff = {1'b0, t} - {1'b0, c};
            if (diff <= {1'b0, s}) return t;
            else                   return c + s;
        end else begin
            diff = {1'b0, c} - {1'b0, t};
            if (diff <= {1'b0, s}) return t;
            else                   return c - s;
        end
    endfunction

    // Move c toward t by at most s along the shorter arc of the mod-256
    // circle. A distance of exactly half a turn (0x80) is resolved upward.
    function automatic logic [7:0] step_circular(
        input logic [7:0] c,
        input logic [7:0] t,
        input logic [7:0] s
    );
        logic [7:0] d;
        logic       up;
        logic [8:0] mag;
        d   = t - c;
        up  = !d[7] || (d == 8'h80);
        // Magnitude needs 9 bits so that 0x80 reads as 128, not -128.
        mag = up ? {1'b0, d} : {1'b0, 8'(~d + 8'd1)};
        if (d == 8'd0)              return c;
        else if (mag <= {1'b0, s})  return t;
        else if (up)                return c + s;
        else                        return c - s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/silent_stepper_if.sv
`default_nettype none
// ============================================================================
// Module      : silent_stepper_if
// Description : Bundle of the update handshake, target arrays and stepped
//               output arrays of silent_stepper.
//               master : upstream select stage (drives START/STEP/targets)
//               slave  : silent_stepper itself
//               Signals: START, STEP, DUTY[], PHASE[] (to slave);
//                        DUTYS[], PHASES[], BUSY, DONE, OVERRUN (from slave)
// Revision    : 1.0 - initial release
// ============================================================================
interface silent_stepper_if #(
    parameter int TRANS_NUM = 249
);
    import silent_pkg::*;

    logic                               START;
    logic [STEP_W-1:0]                  STEP;
    logic [TRANS_NUM-1:0][DUTY_W-1:0]   DUTY;
    logic [TRANS_NUM-1:0][PHASE_W-1:0]  PHASE;
    logic [TRANS_NUM-1:0][DUTY_W-1:0]   DUTYS;
    logic [TRANS_NUM-1:0][PHASE_W-1:0]  PHASES;
    logic                               BUSY;
    logic                               DONE;
    logic                               OVERRUN;

    modport master (
        output START, STEP, DUTY, PHASE,
        input  DUTYS, PHASES, BUSY, DONE, OVERRUN
    );

    modport slave (
        input  START, STEP, DUTY, PHASE,
        output DUTYS, PHASES, BUSY, DONE, OVERRUN
    );

endinterface
`default_nettype wire

// File: rtl/silent_step_unit.sv
`default_nettype none
// ============================================================================
// Module      : silent_step_unit
// Description : Combinational next-value calculation for one transducer
//               channel. Duty always uses the linear saturating rule.
//               Phase uses the circular shortest-path rule when
//               SILENT_PHASE_WRAP_EN is defined, otherwise the linear rule.
// Ports       : i_cur_duty / i_cur_phase  - value currently held
//               i_tgt_duty / i_tgt_phase  - target for this channel
//               i_step                    - maximum change this tick
//               o_next_duty / o_next_phase- value to store
// Revision    : 1.0 - initial release
// ============================================================================
module silent_step_unit
    import silent_pkg::*;
(
    input  wire logic [DUTY_W-1:0]  i_cur_duty,
    input  wire logic [PHASE_W-1:0] i_cur_phase,
    input  wire logic [DUTY_W-1:0]  i_tgt_duty,
    input  wire logic [PHASE_W-1:0] i_tgt_phase,
    input  wire logic [STEP_W-1:0]  i_step,
    output logic      [DUTY_W-1:0]  o_next_duty,
    output logic      [PHASE_W-1:0] o_next_phase
);

    assign o_next_duty = step_linear(i_cur_duty, i_tgt_duty, i_step);

`ifdef SILENT_PHASE_WRAP_EN
    // Phase is an angle: 250 -> 5 should travel through 255/0.
    assign o_next_phase = step_circular(i_cur_phase, i_tgt_phase, i_step);
`else
    // Phase treated as a plain number: 250 -> 5 travels downward.
    assign o_next_phase = step_linear(i_cur_phase, i_tgt_phase, i_step);
`endif

endmodule
`default_nettype wire

// File: rtl/silent_stepper.sv
`default_nettype none
// ============================================================================
// Module      : silent_stepper
// Description : Slew-rate limiter for per-transducer duty/phase targets.
//               Each accepted START launches one serial sweep: channel i is
//               rewritten at the (i+1)-th edge after START, using a single
//               shared silent_step_unit. Phase wrap behaviour is selected by
//               the SILENT_PHASE_WRAP_EN macro (see silent_step_unit).
// Ports       : CLK    - system clock
//               RST_N  - synchronous active-low reset; aborts a sweep and
//                        clears every output channel
//               bus    - silent_stepper_if.slave:
//                        START/STEP in, DUTY[]/PHASE[] targets in,
//                        DUTYS[]/PHASES[] stepped values out,
//                        BUSY (sweep active), DONE (end pulse),
//                        OVERRUN (START seen while busy)
// Parameters  : TRANS_NUM - channel count (1..256)
//               IDX_W     - index width, 2**IDX_W must be >= TRANS_NUM
// Revision    : 1.0 - initial release
// ============================================================================
module silent_stepper
    import silent_pkg::*;
#(
    parameter int TRANS_NUM = 249,
    parameter int IDX_W     = 8
) (
    input  wire logic       CLK,
    input  wire logic       RST_N,
    silent_stepper_if.slave bus
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(TRANS_NUM - 1);

    silent_state_t                      r_state;
    logic [IDX_W-1:0]                   r_idx;
    logic [STEP_W-1:0]                  r_step;
    logic [TRANS_NUM-1:0][DUTY_W-1:0]   r_dutys;
    logic [TRANS_NUM-1:0][PHASE_W-1:0]  r_phases;
    logic                               r_busy;
    logic                               r_done;
    logic                               r_overrun;

    logic [DUTY_W-1:0]                  w_cur_duty;
    logic [PHASE_W-1:0]                 w_cur_phase;
    logic [DUTY_W-1:0]                  w_tgt_duty;
    logic [PHASE_W-1:0]                 w_tgt_phase;
    logic [DUTY_W-1:0]                  w_next_duty;
    logic [PHASE_W-1:0]                 w_next_phase;

    // ------------------------------------------------------------------
    // Channel select: current value and live target of channel r_idx
    // feed the one shared arithmetic unit. Targets are read live, so an
    // upstream change mid-sweep only reaches channels not yet visited.
    // ------------------------------------------------------------------
    assign w_cur_duty  = r_dutys[r_idx];
    assign w_cur_phase = r_phases[r_idx];
    assign w_tgt_duty  = bus.DUTY[r_idx];
    assign w_tgt_phase = bus.PHASE[r_idx];

    silent_step_unit u_step (
        .i_cur_duty   (w_cur_duty),
        .i_cur_phase  (w_cur_phase),
        .i_tgt_duty   (w_tgt_duty),
        .i_tgt_phase  (w_tgt_phase),
        .i_step       (r_step),
        .o_next_duty  (w_next_duty),
        .o_next_phase (w_next_phase)
    );

    // ------------------------------------------------------------------
    // Sweep controller. All status outputs are registered here; DONE and
    // OVERRUN default low so each assertion lasts exactly one cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_step    <= '0;
            r_dutys   <= '0;
            r_phases  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.START) begin
                        // STEP is frozen for the whole sweep.
                        r_step  <= bus.STEP;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    // Only the selected channel is rewritten; every other
                    // channel keeps its value.
                    r_dutys[r_idx]  <= w_next_duty;
                    r_phases[r_idx] <= w_next_phase;
                    // A START here, including on the final edge, is
                    // dropped and only flagged.
                    if (bus.START) begin
                        r_overrun <= 1'b1;
                    end
                    if (r_idx == c_last_idx) begin
                        r_idx   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.DUTYS   = r_dutys;
    assign bus.PHASES  = r_phases;
    assign bus.BUSY    = r_busy;
    assign bus.DONE    = r_done;
    assign bus.OVERRUN = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_silent_stepper.sv
`default_nettype none
// ============================================================================
// Module      : tb_silent_stepper
// Description : Directed self-checking bench for silent_stepper. A table of
//               uniform-target sweeps checks the step arithmetic and sweep
//               timing; hand-written sequences cover per-channel targets,
//               START held/overrun, and reset in the middle of a sweep.
//               Expected phase values follow SILENT_PHASE_WRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_silent_stepper;

    localparam int TRANS_NUM = 249;

    logic CLK;
    logic RST_N;

    silent_stepper_if #(.TRANS_NUM(TRANS_NUM)) bus ();

    silent_stepper #(
        .TRANS_NUM (TRANS_NUM),
        .IDX_W     (8)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_d [TRANS_NUM];
    logic [7:0] exp_p [TRANS_NUM];

    typedef struct {
        logic [7:0] step;
        logic [7:0] duty;
        logic [7:0] phase;
        logic [7:0] exp_duty;
        logic [7:0] exp_ph_wrap;
        logic [7:0] exp_ph_lin;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Compare every output channel against exp_d/exp_p; one check each array.
    task automatic check_chans(input string name);
        int bad_d = -1;
        int bad_p = -1;
        for (int i = 0; i < TRANS_NUM; i++) begin
            if (bad_d < 0 && bus.DUTYS[i] !== exp_d[i])  bad_d = i;
            if (bad_p < 0 && bus.PHASES[i] !== exp_p[i]) bad_p = i;
        end
        n_checks += 2;
        if (bad_d >= 0) begin
            n_errors++;
            $display("FAIL %s duty ch%0d: got %0d, required %0d", name, bad_d,
                     bus.DUTYS[bad_d], exp_d[bad_d]);
        end
        if (bad_p >= 0) begin
            n_errors++;
            $display("FAIL %s phase ch%0d: got %0d, required %0d", name, bad_p,
                     bus.PHASES[bad_p], exp_p[bad_p]);
        end
    endtask

    task automatic set_targets(input logic [7:0] d, input logic [7:0] p);
        for (int i = 0; i < TRANS_NUM; i++) begin
            bus.DUTY[i]  = d;
            bus.PHASE[i] = p;
        end
    endtask

    // One START pulse, then watch BUSY/DONE/OVERRUN through the sweep.
    task automatic run_sweep(input logic [7:0] s, input string name);
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at  = -1;
        int ovr_cnt  = 0;
        bus.STEP  = s;
        bus.START = 1'b1;
        tick();                       // edge k
        bus.START = 1'b0;
        for (int n = 0; n < TRANS_NUM + 3; n++) begin
            if (bus.BUSY)    busy_cnt++;
            if (bus.OVERRUN) ovr_cnt++;
            if (bus.DONE) begin
                done_cnt++;
                done_at = n;
            end
            tick();
        end
        check({name, " busy cycles"}, busy_cnt, TRANS_NUM);
        check({name, " done count"}, done_cnt, 1);
        check({name, " done edge"}, done_at, TRANS_NUM);
        check({name, " overrun"}, ovr_cnt, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] p_exp;
        int         done_cnt;
        int         busy_seen;

        vecs[0]  = '{8'd50,  8'd200, 8'd0,   8'd50,  8'd0,   8'd0};
        vecs[1]  = '{8'd50,  8'd200, 8'd0,   8'd100, 8'd0,   8'd0};
        vecs[2]  = '{8'd50,  8'd200, 8'd0,   8'd150, 8'd0,   8'd0};
        vecs[3]  = '{8'd50,  8'd200, 8'd0,   8'd200, 8'd0,   8'd0};
        vecs[4]  = '{8'd255, 8'd10,  8'd250, 8'd10,  8'd250, 8'd250};
        vecs[5]  = '{8'd4,   8'd12,  8'd5,   8'd12,  8'd254, 8'd246};
        vecs[6]  = '{8'd4,   8'd12,  8'd5,   8'd12,  8'd2,   8'd242};
        vecs[7]  = '{8'd4,   8'd12,  8'd5,   8'd12,  8'd5,   8'd238};
        vecs[8]  = '{8'd20,  8'd0,   8'd5,   8'd0,   8'd5,   8'd218};
        vecs[9]  = '{8'd0,   8'd77,  8'd100, 8'd0,   8'd5,   8'd218};
        vecs[10] = '{8'd255, 8'd100, 8'd0,   8'd100, 8'd0,   8'd0};
        vecs[11] = '{8'd30,  8'd0,   8'd200, 8'd70,  8'd226, 8'd30};
        vecs[12] = '{8'd128, 8'd255, 8'd128, 8'd198, 8'd128, 8'd128};
        vecs[13] = '{8'd10,  8'd255, 8'd0,   8'd208, 8'd138, 8'd118};

        RST_N     = 1'b0;
        bus.START = 1'b0;
        bus.STEP  = 8'd0;
        set_targets(8'd0, 8'd0);
        repeat (3) tick();

        // ---------------- reset state ----------------
        check("reset busy", bus.BUSY, 0);
        check("reset done", bus.DONE, 0);
        check("reset overrun", bus.OVERRUN, 0);
        for (int i = 0; i < TRANS_NUM; i++) begin
            exp_d[i] = 8'd0;
            exp_p[i] = 8'd0;
        end
        check_chans("reset outputs");
        RST_N = 1'b1;
        tick();

        // ---------------- table of uniform sweeps ----------------
        for (int v = 0; v < 14; v++) begin
            set_targets(vecs[v].duty, vecs[v].phase);
            run_sweep(vecs[v].step, $sformatf("vec%0d", v));
`ifdef SILENT_PHASE_WRAP_EN
            p_exp = vecs[v].exp_ph_wrap;
`else
            p_exp = vecs[v].exp_ph_lin;
`endif
            for (int i = 0; i < TRANS_NUM; i++) begin
                exp_d[i] = vecs[v].exp_duty;
                exp_p[i] = p_exp;
            end
            check_chans($sformatf("vec%0d", v));
        end

        // ---------------- distinct target per channel ----------------
        for (int i = 0; i < TRANS_NUM; i++) begin
            bus.DUTY[i]  = 8'((i * 3 + 1) & 255);
            bus.PHASE[i] = 8'(255 - i);
            exp_d[i]     = 8'((i * 3 + 1) & 255);
            exp_p[i]     = 8'(255 - i);
        end
        run_sweep(8'd255, "perchan");
        check_chans("perchan");

        // ---------------- START held 3 cycles, START on final edge ----------------
        bus.STEP  = 8'd7;
        bus.START = 1'b1;
        tick();                                   // edge k: accepted
        check("held busy", bus.BUSY, 1);
        check("held ovr k", bus.OVERRUN, 0);
        tick();                                   // edge k+1
        check("held ovr k+1", bus.OVERRUN, 1);
        tick();                                   // edge k+2
        bus.START = 1'b0;
        check("held ovr k+2", bus.OVERRUN, 1);
        tick();                                   // edge k+3
        check("held ovr k+3", bus.OVERRUN, 0);
        done_cnt = 0;
        // Now after edge k+3; advance to just after edge k+TRANS_NUM-1.
        for (int n = 3; n < TRANS_NUM - 1; n++) begin
            if (bus.DONE) done_cnt++;
            tick();
        end
        check("final-1 busy", bus.BUSY, 1);
        bus.START = 1'b1;
        tick();                                   // edge k+TRANS_NUM
        bus.START = 1'b0;
        if (bus.DONE) done_cnt++;
        check("final done", bus.DONE, 1);
        check("final ovr", bus.OVERRUN, 1);
        check("final busy", bus.BUSY, 0);
        tick();
        check("after final busy", bus.BUSY, 0);
        check("after final ovr", bus.OVERRUN, 0);
        if (bus.DONE) done_cnt++;
        check("held done count", done_cnt, 1);
        check_chans("held unchanged");

        // ---------------- reset in the middle of a sweep ----------------
        set_targets(8'd200, 8'd200);
        bus.STEP  = 8'd255;
        bus.START = 1'b1;
        tick();                                   // edge k
        bus.START = 1'b0;
        repeat (100) tick();                      // after edge k+100
        check("mid ch99 duty", bus.DUTYS[99], 200);
        check("mid ch100 duty", bus.DUTYS[100], 45);
        check("mid busy", bus.BUSY, 1);
        RST_N = 1'b0;
        tick();                                   // edge k+101 resets
        RST_N = 1'b1;
        for (int i = 0; i < TRANS_NUM; i++) begin
            exp_d[i] = 8'd0;
            exp_p[i] = 8'd0;
        end
        check_chans("mid reset");
        check("mid reset busy", bus.BUSY, 0);
        done_cnt  = 0;
        busy_seen = 0;
        for (int n = 0; n < TRANS_NUM + 10; n++) begin
            if (bus.DONE) done_cnt++;
            if (bus.BUSY) busy_seen++;
            tick();
        end
        check("aborted no done", done_cnt, 0);
        check("aborted no busy", busy_seen, 0);

        run_sweep(8'd100, "restart");
        for (int i = 0; i < TRANS_NUM; i++) begin
            exp_d[i] = 8'd100;
`ifdef SILENT_PHASE_WRAP_EN
            exp_p[i] = 8'd200;
`else
            exp_p[i] = 8'd100;
`endif
        end
        check_chans("restart");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
